// File: rtl/neurosync_controller_single_uc_pkg.sv
// Shared definitions for the single-player NeuroSync control unit:
// state codes, question opcodes and the score ceiling.
package neurosync_pkg;

  typedef enum logic [3:0] {
    INICIAL      = 4'd0,
    ZERA         = 4'd1,
    ESCOLHE_MODO = 4'd2,
    REGISTRA     = 4'd3,
    PREP         = 4'd4,
    POSICIONA    = 4'd5,
    DESPACHA     = 4'd6,
    PLAY_INICIA  = 4'd7,
    PLAY_ESPERA  = 4'd8,
    FAIXA_MEDE   = 4'd9,
    ACERTO       = 4'd10,
    ERRO         = 4'd11,
    PROXIMA      = 4'd12,
    FIM          = 4'd13
  } state_t;

  localparam logic [1:0] OP_PLAY  = 2'b00;
  localparam logic [1:0] OP_FAIXA = 2'b01;
  localparam logic [1:0] OP_PLAY2 = 2'b10;
  localparam logic [1:0] OP_LIVRE = 2'b11;

  localparam logic [3:0] MAX_PONTOS = 4'd8;

endpackage

// File: rtl/neurosync_controller_single_uc_if.sv
// Control/status bundle between the NeuroSync control unit (master)
// and the single-player datapath (slave).
interface neurosync_controller_single_uc_if;
  logic       iniciar;
  logic       confirma;
  logic [1:0] opcode;
  logic       pronto_play;
  logic       acertou_play;
  logic       acertou_faixa;
  logic       is_ultima_pergunta;
  logic       zera;
  logic       registra_modo;
  logic       zera_prep_jogo;
  logic       set_pos;
  logic       jogar_play;
  logic       jogando;
  logic       medir;
  logic       enable_mov;
  logic       show_leds_servo;
  logic       conta_pergunta;
  logic [3:0] pontos;
  logic       fim_jogo;
  logic [3:0] db_estado;

  modport master (
    input  iniciar, confirma, opcode, pronto_play, acertou_play,
           acertou_faixa, is_ultima_pergunta,
    output zera, registra_modo, zera_prep_jogo, set_pos, jogar_play,
           jogando, medir, enable_mov, show_leds_servo, conta_pergunta,
           pontos, fim_jogo, db_estado
  );

  modport slave (
    output iniciar, confirma, opcode, pronto_play, acertou_play,
           acertou_faixa, is_ultima_pergunta,
    input  zera, registra_modo, zera_prep_jogo, set_pos, jogar_play,
           jogando, medir, enable_mov, show_leds_servo, conta_pergunta,
           pontos, fim_jogo, db_estado
  );
endinterface

// File: rtl/neurosync_controller_single_uc_edge_detector.sv
// Rising-edge detector for a button level; the input is registered once,
// so the pulse appears one cycle after the level rises.
module edge_detector (
  input  logic clock,
  input  logic reset,
  input  logic sinal,
  output logic pulso
);
  logic sinal_q;
  logic prev_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      sinal_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sinal_q <= sinal;
      prev_q  <= sinal_q;
    end
  end

  assign pulso = sinal_q & ~prev_q;
endmodule

// File: rtl/neurosync_controller_single_uc.sv
// Control unit sequencing the single-player NeuroSync datapath through
// mode selection, eight questions and the end-of-game state.
module neurosync_controller_single_uc
  import neurosync_pkg::*;
#(
  parameter int unsigned TIMEOUT_CICLOS = 50_000_000,
  parameter int unsigned MEDIR_CICLOS   = 25_000_000,
  parameter int unsigned TIMER_BITS     = 26
) (
  input logic clock,
  input logic reset,
  neurosync_controller_single_uc_if.master bus
);
  localparam logic [TIMER_BITS-1:0] TMO_LAST = TIMER_BITS'(TIMEOUT_CICLOS - 1);
  localparam logic [TIMER_BITS-1:0] MED_LAST = TIMER_BITS'(MEDIR_CICLOS - 1);

  state_t                state_q, state_d;
  logic [TIMER_BITS-1:0] timer_q, timer_d;
  logic [3:0]            pontos_q, pontos_d;
  logic                  flag_q, flag_d;
  logic                  ini_edge, conf_edge;

  edge_detector u_ed_iniciar (
    .clock (clock),
    .reset (reset),
    .sinal (bus.iniciar),
    .pulso (ini_edge)
  );

  edge_detector u_ed_confirma (
    .clock (clock),
    .reset (reset),
    .sinal (bus.confirma),
    .pulso (conf_edge)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= INICIAL;
      timer_q  <= '0;
      pontos_q <= '0;
      flag_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      pontos_q <= pontos_d;
      flag_q   <= flag_d;
    end
  end

  always_comb begin
    state_d             = state_q;
    timer_d             = '0;
    pontos_d            = pontos_q;
    flag_d              = flag_q;
    bus.zera            = 1'b0;
    bus.registra_modo   = 1'b0;
    bus.zera_prep_jogo  = 1'b0;
    bus.set_pos         = 1'b0;
    bus.jogar_play      = 1'b0;
    bus.jogando         = 1'b0;
    bus.medir           = 1'b0;
    bus.enable_mov      = 1'b0;
    bus.show_leds_servo = 1'b0;
    bus.conta_pergunta  = 1'b0;
    bus.fim_jogo        = 1'b0;

    case (state_q)
      INICIAL: if (ini_edge) state_d = ZERA;
      ZERA: begin
        bus.zera = 1'b1;
        state_d  = ESCOLHE_MODO;
      end
      ESCOLHE_MODO: begin
        bus.show_leds_servo = 1'b1;
        bus.enable_mov      = 1'b1;
        if (conf_edge) state_d = REGISTRA;
      end
      REGISTRA: begin
        bus.registra_modo = 1'b1;
        state_d           = PREP;
      end
      PREP: begin
        bus.zera_prep_jogo = 1'b1;
        flag_d             = 1'b0;
        state_d            = POSICIONA;
      end
      POSICIONA: begin
        bus.set_pos = 1'b1;
        state_d     = DESPACHA;
      end
      DESPACHA: begin
        case (bus.opcode)
          OP_FAIXA: state_d = FAIXA_MEDE;
          OP_LIVRE: state_d = ACERTO;
          default:  state_d = PLAY_INICIA;
        endcase
      end
      PLAY_INICIA: begin
        bus.jogar_play = 1'b1;
        state_d        = PLAY_ESPERA;
      end
      PLAY_ESPERA: begin
        bus.jogando    = 1'b1;
        bus.enable_mov = 1'b1;
        timer_d        = timer_q + 1'b1;
        // a result arriving on the timeout cycle still counts
        if (bus.pronto_play) state_d = bus.acertou_play ? ACERTO : ERRO;
        else if (timer_q == TMO_LAST) state_d = ERRO;
      end
      FAIXA_MEDE: begin
        bus.jogando = 1'b1;
        bus.medir   = 1'b1;
        timer_d     = timer_q + 1'b1;
        if (bus.acertou_faixa) flag_d = 1'b1;
        if (timer_q == MED_LAST)
          state_d = (flag_q | bus.acertou_faixa) ? ACERTO : ERRO;
      end
      ACERTO: begin
        if (pontos_q < MAX_PONTOS) pontos_d = pontos_q + 4'd1;
        state_d = PROXIMA;
      end
      ERRO: state_d = PROXIMA;
      PROXIMA: begin
        if (bus.is_ultima_pergunta) begin
          state_d = FIM;
        end else begin
          bus.conta_pergunta = 1'b1;
          state_d            = PREP;
        end
      end
      FIM: begin
        bus.fim_jogo = 1'b1;
        if (ini_edge) state_d = ZERA;
      end
      default: state_d = INICIAL;
    endcase

    // timer restarts on every state entry; score is already clear inside ZERA
    if (state_d != state_q) timer_d = '0;
    if (state_d == ZERA) pontos_d = '0;
  end

  assign bus.pontos    = pontos_q;
  assign bus.db_estado = state_q;
endmodule

// File: tb/tb_neurosync_controller_single_uc.sv
// Directed + randomized bench for the NeuroSync single-player control unit.
module tb_neurosync_controller_single_uc;
  localparam int unsigned T = 20;
  localparam int unsigned M = 10;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned exp_pontos = 0;
  int unsigned conta_cnt = 0;

  neurosync_controller_single_uc_if bus ();

  neurosync_controller_single_uc #(
    .TIMEOUT_CICLOS (T),
    .MEDIR_CICLOS   (M),
    .TIMER_BITS     (8)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  always @(negedge clock) if (bus.conta_pergunta === 1'b1) conta_cnt++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // {zera, registra_modo, zera_prep_jogo, set_pos, jogar_play, jogando,
  //  medir, enable_mov, show_leds_servo, fim_jogo}
  function automatic logic [9:0] exp_ctl(input logic [3:0] s);
    case (s)
      4'd1:    return 10'b1000000000;
      4'd2:    return 10'b0000000110;
      4'd3:    return 10'b0100000000;
      4'd4:    return 10'b0010000000;
      4'd5:    return 10'b0001000000;
      4'd7:    return 10'b0000100000;
      4'd8:    return 10'b0000010100;
      4'd9:    return 10'b0000011000;
      4'd13:   return 10'b0000000001;
      default: return 10'b0000000000;
    endcase
  endfunction

  function automatic logic [9:0] ctl_now();
    return {bus.zera, bus.registra_modo, bus.zera_prep_jogo, bus.set_pos,
            bus.jogar_play, bus.jogando, bus.medir, bus.enable_mov,
            bus.show_leds_servo, bus.fim_jogo};
  endfunction

  task automatic chk_st(input logic [3:0] s);
    chk("db_estado", 32'(bus.db_estado), 32'(s));
    chk("ctl_outputs", 32'(ctl_now()), 32'(exp_ctl(s)));
  endtask

  task automatic start_game();
    bus.is_ultima_pergunta = 1'b0;
    bus.iniciar = 1'b1;
    step();
    chk("pre_edge_state", 32'(bus.db_estado), 32'(bus.db_estado == 4'd13 ? 13 : 0));
    bus.iniciar = 1'b0;
    step();
    chk_st(4'd1);
    exp_pontos = 0;
    chk("pontos_zera", 32'(bus.pontos), 32'(exp_pontos));
    step();
    chk_st(4'd2);
    bus.confirma = 1'b1;
    step();
    chk_st(4'd2);
    bus.confirma = 1'b0;
    step();
    chk_st(4'd3);
    step();
    chk_st(4'd4);
  endtask

  // Runs one question from PREP through PROXIMA; model: a play hits only if
  // the result arrives before the timeout, free questions always hit.
  task automatic question(input logic [1:0] op, input bit hit, input int unsigned dly, input bit last);
    bit h;
    int unsigned mcnt;
    chk_st(4'd4);
    bus.opcode = op;
    bus.is_ultima_pergunta = last;
    step(); chk_st(4'd5);
    step(); chk_st(4'd6);
    step();
    case (op)
      2'b11: h = 1'b1;
      2'b01: h = hit;
      default: h = hit && (dly < T);
    endcase
    if (op == 2'b11) begin
      chk_st(4'd10);
    end else if (op == 2'b01) begin
      chk_st(4'd9);
      mcnt = 0;
      for (int unsigned c = 0; c < M; c++) begin
        if (bus.medir === 1'b1) mcnt++;
        bus.acertou_faixa = hit && (c == dly);
        step();
      end
      bus.acertou_faixa = 1'b0;
      chk("medir_cycles", mcnt, M);
      chk_st(h ? 4'd10 : 4'd11);
    end else begin
      chk_st(4'd7);
      step();
      chk_st(4'd8);
      if (dly < T) begin
        for (int unsigned c = 0; c < dly; c++) step();
        bus.pronto_play = 1'b1;
        bus.acertou_play = hit;
        step();
        bus.pronto_play = 1'b0;
        bus.acertou_play = 1'b0;
      end else begin
        for (int unsigned c = 0; c < T - 1; c++) step();
        chk("last_wait_cycle", 32'(bus.db_estado), 32'd8);
        step();
      end
      chk_st(h ? 4'd10 : 4'd11);
    end
    exp_pontos = (exp_pontos + h > 8) ? 8 : exp_pontos + h;
    step();
    chk_st(4'd12);
    chk("conta_pergunta", 32'(bus.conta_pergunta), 32'(!last));
    chk("pontos", 32'(bus.pontos), 32'(exp_pontos));
    step();
    chk_st(last ? 4'd13 : 4'd4);
  endtask

  initial begin
    bus.iniciar = 1'b0; bus.confirma = 1'b0; bus.opcode = 2'b00;
    bus.pronto_play = 1'b0; bus.acertou_play = 1'b0;
    bus.acertou_faixa = 1'b0; bus.is_ultima_pergunta = 1'b0;
    @(negedge clock);
    step(); step();
    reset = 1'b0;
    chk_st(4'd0);
    chk("reset_pontos", 32'(bus.pontos), 32'd0);
    chk("reset_conta", 32'(bus.conta_pergunta), 32'd0);

    start_game();
    question(2'b00, 1'b1, 5, 1'b0);    // play hit after 5 cycles
    question(2'b00, 1'b0, 99, 1'b0);   // play timeout
    question(2'b01, 1'b1, 3, 1'b0);    // faixa pulse at window cycle 3
    question(2'b10, 1'b1, T - 1, 1'b0); // result on the timeout cycle
    question(2'b01, 1'b0, 0, 1'b0);    // faixa miss

    // confirma edge while waiting for play is ignored
    bus.opcode = 2'b00;
    step(); step(); step(); step();
    chk_st(4'd8);
    bus.confirma = 1'b1;
    step(); chk("ignore_confirma", 32'(bus.db_estado), 32'd8);
    bus.confirma = 1'b0;
    step(); chk("ignore_confirma", 32'(bus.db_estado), 32'd8);
    step(); chk("ignore_confirma", 32'(bus.db_estado), 32'd8);
    bus.pronto_play = 1'b1;
    bus.acertou_play = 1'b0;
    step();
    bus.pronto_play = 1'b0;
    chk_st(4'd11);
    step(); step();
    chk("pontos_after_miss", 32'(bus.pontos), 32'(exp_pontos));
    chk_st(4'd4);

    // reset in the middle of a measurement window
    bus.opcode = 2'b01;
    step(); step(); step();
    chk_st(4'd9);
    step(); step(); step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk_st(4'd0);
    chk("reset_mid_pontos", 32'(bus.pontos), 32'd0);

    // illegal state code recovers to INICIAL
    force dut.state_q = neurosync_pkg::state_t'(4'd14);
    #1 release dut.state_q;
    chk("illegal_forced", 32'(bus.db_estado), 32'd14);
    step();
    chk_st(4'd0);

    // eight free-hit questions
    start_game();
    conta_cnt = 0;
    for (int unsigned q = 0; q < 8; q++) question(2'b11, 1'b0, 0, q == 7);
    chk("free_pontos", 32'(bus.pontos), 32'd8);
    chk("free_conta_pulses", conta_cnt, 32'd7);

    // randomized games, each starting from FIM
    for (int unsigned g = 0; g < 3; g++) begin
      start_game();
      conta_cnt = 0;
      for (int unsigned q = 0; q < 8; q++) begin
        logic [1:0] op;
        bit hit;
        int unsigned dly;
        op  = 2'($urandom_range(0, 3));
        hit = 1'($urandom_range(0, 1));
        dly = (op == 2'b01) ? $urandom_range(0, M - 1) : $urandom_range(0, T + 3);
        question(op, hit, dly, q == 7);
      end
      chk("rand_conta_pulses", conta_cnt, 32'd7);
      chk("rand_final_pontos", 32'(bus.pontos), 32'(exp_pontos));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
